// File: rtl/mem_wb_stage_buf_if.sv
// ============================================================================
// Module     : mem_wb_stage_buf_if
// Description: MEM->WB stage bus: MEM-side beat in, WB-side beat out.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wb_stage_buf_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_memtoreg;
    logic              in_regwrite;
    logic [DATA_W-1:0] in_mem;
    logic [DATA_W-1:0] in_alu;
    logic [RD_W-1:0]   in_rd;

    logic              out_valid;
    logic              out_ready;
    logic              out_memtoreg;
    logic              out_regwrite;
    logic [DATA_W-1:0] out_mem;
    logic [DATA_W-1:0] out_alu;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_wdata;

    modport slave (
        input  in_valid, in_memtoreg, in_regwrite, in_mem, in_alu, in_rd, out_ready,
        output in_ready, out_valid, out_memtoreg, out_regwrite, out_mem, out_alu,
               out_rd, out_wdata
    );

    modport master (
        output in_valid, in_memtoreg, in_regwrite, in_mem, in_alu, in_rd, out_ready,
        input  in_ready, out_valid, out_memtoreg, out_regwrite, out_mem, out_alu,
               out_rd, out_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_buf.sv
// ============================================================================
// Module     : mem_wb_stage_buf
// Description: MEM->WB pipeline stage with valid/ready, optional skid entry,
//              flush and bubble-gated writeback controls.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage_buf #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int SKID   = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               flush_i,
    mem_wb_stage_buf_if.slave       bus,
    output logic [1:0]              occupancy_o
);

    localparam int c_PAY_W = 2 + 2*DATA_W + RD_W;

    logic [c_PAY_W-1:0] w_in_pay;
    logic [c_PAY_W-1:0] main_pay_q, main_pay_d;
    logic [c_PAY_W-1:0] skid_pay_q, skid_pay_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_main_free;

    assign w_in_pay    = {bus.in_memtoreg, bus.in_regwrite, bus.in_mem, bus.in_alu, bus.in_rd};
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_main_free = !main_valid_q | bus.out_ready;

    // Skid entry is always older than the input, so it wins the refill of main.
    always_comb begin
        main_valid_d = main_valid_q;
        main_pay_d   = main_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (w_main_free) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_pay_d   = skid_pay_q;
                    skid_valid_d = 1'b0;
                end else if (w_accept) begin
                    main_valid_d = 1'b1;
                    main_pay_d   = w_in_pay;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (w_accept) begin
                skid_valid_d = 1'b1;
                skid_pay_d   = w_in_pay;
            end
        end else begin
            if (w_accept) begin
                main_valid_d = 1'b1;
                main_pay_d   = w_in_pay;
            end else if (bus.out_ready) begin
                main_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_pay_q   <= '0;
            skid_pay_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_pay_q   <= main_pay_d;
            skid_pay_q   <= skid_pay_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_rdy
            // Registered ready: no combinational path from out_ready back to MEM.
            logic ready_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) ready_q <= 1'b0;
                else     ready_q <= !skid_valid_d;
            end
            assign w_in_ready = ready_q;
        end else begin : g_comb_rdy
            logic alive_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) alive_q <= 1'b0;
                else     alive_q <= 1'b1;
            end
            assign w_in_ready = alive_q & w_main_free;
        end
    endgenerate

    logic w_mt;
    logic w_rw;

    assign w_mt = main_valid_q & main_pay_q[c_PAY_W-1];
    assign w_rw = main_valid_q & main_pay_q[c_PAY_W-2];

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = main_valid_q;
    assign bus.out_memtoreg = w_mt;
    assign bus.out_regwrite = w_rw;
    assign bus.out_mem      = main_pay_q[c_PAY_W-3 -: DATA_W];
    assign bus.out_alu      = main_pay_q[RD_W+DATA_W-1 -: DATA_W];
    assign bus.out_rd       = main_valid_q ? main_pay_q[RD_W-1:0] : '0;
    assign bus.out_wdata    = w_mt ? main_pay_q[c_PAY_W-3 -: DATA_W]
                                   : main_pay_q[RD_W+DATA_W-1 -: DATA_W];
    assign occupancy_o      = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

`default_nettype wire
